booth_radix4_seq_multiplier: RTL and testbench
==============================================

Name: booth_radix4_seq_multiplier

Overview:
Sequential radix-4 (modified) Booth multiplier, parametrised in operand widths. It retires one Booth digit (two multiplier bits) per clock and supports signed and unsigned modes, selected per operation. A start/busy/done handshake lets it sit behind a control FSM or datapath sequencer as a shared, low-area multiply unit. It is the multi-cycle, width-generic successor to the team's single-shot combinational Booth multiplier.

Parameters:
MW, 8, multiplicand width in bits (>= 2)
RW, 8, multiplier width in bits (>= 2; odd values allowed)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request a multiply; sampled only when accepting
sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
multiplicand  input  MW  operand A; sampled with start
multiplier  input  RW  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when product is updated
product  output  MW+RW  result register; holds until the next completion

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, busy=0, done=0, product=0, internal counter/accumulator=0. Reset wins over every other event.
- Multiplier extension: operand B is extended by one bit (sign bit if sgn=1, 0 if sgn=0) to RW+1 bits. It is then extended once more to even width RE if needed. ITER = RE/2. Examples: RW=8 gives ITER=5; RW=4 gives ITER=3.
- Multiplicand extension: operand A is extended to MW+2 bits (sign or zero, per sgn).
- States:
  - IDLE: start=1 loads operands and sgn, clears accumulator and counter, goes to RUN, busy=1.
  - RUN: each edge recodes the triplet {b[2i+1], b[2i], b[2i-1]} with b[-1]=0:
    - 000 and 111 give 0
    - 001 and 010 give +A
    - 011 gives +2A
    - 100 gives -2A
    - 101 and 110 give -A
  - RUN, continued: each partial product is added at weight 4^i, then the counter increments. On the ITER-th RUN edge, the low MW+RW bits of the final sum are written to product and the state goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. start=1 in this cycle is accepted exactly as in IDLE, which gives back-to-back operation. Otherwise the state returns to IDLE.
- Latency: if start is accepted at edge E0, done is high in the cycle following edge E0+ITER. Throughput is one result per ITER+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled, and the in-flight result is unaffected.
- Inputs other than start and sgn are don't-care outside the accepting cycle.
- product keeps its old value throughout RUN and changes only on the completion edge. It is stable between done pulses.
- Arithmetic: internal accumulator is wide enough (>= MW+RE+2 bits) that no intermediate overflow occurs. The MW+RW-bit result is exact for all operand pairs in both modes, including the corner cases -2^(MW-1) × -2^(RW-1) and unsigned all-ones × all-ones.
- Reset asserted mid-RUN aborts the operation: the next edge yields IDLE, busy=0, done=0, product=0. No stale done pulse follows.

Test Plan:
1. Hold rst_n=0 for 2 edges, then release with start=0 -> busy=0, done=0, product=0; outputs stay static in IDLE.
2. MW=RW=8, sgn=1, start pulse with 4×6, then 4×-8, 1×-6, -5×-8 -> product 24, 0xFFE0, 0xFFFA, 40 respectively. Each done pulse arrives exactly 5 cycles after its start edge; busy is high for 5 cycles.
3. MW=RW=8 corners:
   - sgn=0, 255×255 -> 0xFE01
   - sgn=1, -128×-128 -> 0x4000
   - sgn=1, -128×127 -> 0xC080
   - sgn=1, 0×-1 -> 0
4. Handshake:
   - Pulse start again 2 cycles into RUN with different operands -> ignored; first result is correct and done is 1 pulse.
   - Assert start in the DONE cycle with 3×-4 -> accepted; next done 5 cycles later with product 0xFFF4.
5. Reset mid-operation: rst_n=0 at the 3rd RUN cycle -> next edge busy=0, done=0, product=0, and no done pulse follows. A subsequent 7×9 signed gives 63.
6. Parametrised instance MW=5, RW=4 (ITER=3), sgn=1:
   - -5×-8 -> product 9'd40, done 3 cycles after start
   - 15×7 -> 105
   - -16×7 -> 9'h190 (-112)

Source files
------------

// File: rtl/booth_radix4_seq_multiplier.sv
// booth_radix4_seq_multiplier: sequential radix-4 Booth multiplier, one digit per clock, signed/unsigned per operation
module booth_radix4_seq_multiplier #(
    parameter int MW = 8,
    parameter int RW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sgn,
    input  logic [MW-1:0]      multiplicand,
    input  logic [RW-1:0]      multiplier,
    output logic               busy,
    output logic               done,
    output logic [MW+RW-1:0]   product
);
    localparam int RE   = (RW % 2 == 1) ? RW + 1 : RW + 2;
    localparam int ITER = RE / 2;
    localparam int AW   = MW + RE + 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [MW+1:0]          a_reg;
    logic [RE:0]            b_reg;
    logic [CW-1:0]          cnt;
    logic signed [AW-1:0]   acc, sum;
    logic signed [MW+2:0]   a_w, pp;
    logic [2:0]             trip;

    // b_reg carries b[-1] in bit 0, so the current Booth triplet is always its low 3 bits
    always_comb begin
        a_w  = signed'({a_reg[MW+1], a_reg});
        trip = b_reg[2:0];
        pp   = (trip == 3'b001 || trip == 3'b010) ? a_w :
               (trip == 3'b011)                   ? a_w <<< 1 :
               (trip == 3'b100)                   ? -(a_w <<< 1) :
               (trip == 3'b101 || trip == 3'b110) ? -a_w : '0;
        sum  = acc + (AW'(pp) << {cnt, 1'b0});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            acc     <= '0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                acc   <= sum;
                b_reg <= b_reg >> 2;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    product <= sum[MW+RW-1:0];
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            end else if (start) begin
                a_reg <= {{2{sgn & multiplicand[MW-1]}}, multiplicand};
                b_reg <= {{(RE-RW){sgn & multiplier[RW-1]}}, multiplier, 1'b0};
                acc   <= '0;
                cnt   <= '0;
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// tb_booth_radix4_seq_multiplier: directed vectors on an 8x8 and a 5x4 instance
module tb_booth_radix4_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st8 = 1'b0, sg8 = 1'b0, st5 = 1'b0, sg5 = 1'b0;
    logic [7:0]  mc8 = '0, mp8 = '0;
    logic [4:0]  mc5 = '0;
    logic [3:0]  mp5 = '0;
    logic        busy8, done8, busy5, done5;
    logic [15:0] p8;
    logic [8:0]  p5;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    booth_radix4_seq_multiplier #(.MW(8), .RW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sgn(sg8), .multiplicand(mc8),
        .multiplier(mp8), .busy(busy8), .done(done8), .product(p8)
    );

    booth_radix4_seq_multiplier #(.MW(5), .RW(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(st5), .sgn(sg5), .multiplicand(mc5),
        .multiplier(mp5), .busy(busy5), .done(done5), .product(p5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive start for exactly one rising edge; call from a falling edge
    task automatic go(input bit w5, input bit s, input logic [31:0] a, input logic [31:0] b);
        if (w5) begin
            st5 = 1'b1; sg5 = s; mc5 = a[4:0]; mp5 = b[3:0];
        end else begin
            st8 = 1'b1; sg8 = s; mc8 = a[7:0]; mp8 = b[7:0];
        end
        @(posedge clk);
        #1;
        st8 = 1'b0;
        st5 = 1'b0;
    endtask

    // returns at the falling edge of the done cycle
    task automatic wait_done(input bit w5, input int iter, input logic [31:0] exp, input string tag, input bit poke);
        int lat = 0, nb = 0;
        bit moved = 0;
        logic [31:0] held = w5 ? 32'(p5) : 32'(p8);
        forever begin
            @(negedge clk);
            if (w5 ? done5 : done8) break;
            if (w5 ? busy5 : busy8) nb++;
            if ((w5 ? 32'(p5) : 32'(p8)) != held) moved = 1;
            lat++;
            if (poke) begin
                st8 = (lat == 2);
                if (lat == 2) begin
                    mc8 = 8'd77; mp8 = 8'd3;
                end
            end
            if (lat > 40) break;
        end
        st8 = 1'b0;
        check({tag, "_lat"}, lat, iter);
        check({tag, "_busy"}, nb, iter);
        check({tag, "_hold"}, 32'(moved), 0);
        check({tag, "_prod"}, w5 ? 32'(p5) : 32'(p8), exp);
    endtask

    task automatic op(input bit w5, input bit s, input logic [31:0] a, input logic [31:0] b,
                      input int iter, input logic [31:0] exp, input string tag);
        @(negedge clk);
        go(w5, s, a, b);
        wait_done(w5, iter, exp, tag, 1'b0);
        @(negedge clk);
        check({tag, "_pulse"}, w5 ? 32'(done5) : 32'(done8), 0);
    endtask

    initial begin
        int nd;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_prod8", 32'(p8), 0);
        check("rst_busy5", 32'(busy5), 0);
        check("rst_done5", 32'(done5), 0);
        check("rst_prod5", 32'(p5), 0);
        repeat (3) @(negedge clk);
        check("idle_busy8", 32'(busy8), 0);
        check("idle_prod8", 32'(p8), 0);

        op(0, 1, 4, 6, 5, 32'h0018, "s4x6");
        op(0, 1, 4, -8, 5, 32'hFFE0, "s4xm8");
        op(0, 1, 1, -6, 5, 32'hFFFA, "s1xm6");
        op(0, 1, -5, -8, 5, 32'h0028, "sm5xm8");

        op(0, 0, 255, 255, 5, 32'hFE01, "u255x255");
        op(0, 1, -128, -128, 5, 32'h4000, "sm128xm128");
        op(0, 1, -128, 127, 5, 32'hC080, "sm128x127");
        op(0, 1, 0, -1, 5, 32'h0000, "s0xm1");

        @(negedge clk);
        go(0, 0, 10, 10);
        wait_done(0, 5, 32'd100, "ignore", 1'b1);
        @(negedge clk);
        check("ignore_pulse", 32'(done8), 0);

        @(negedge clk);
        go(0, 1, 10, -3);
        wait_done(0, 5, 32'hFFE2, "b2b_first", 1'b0);
        go(0, 1, 3, -4);
        wait_done(0, 5, 32'hFFF4, "b2b_second", 1'b0);
        @(negedge clk);
        check("b2b_pulse", 32'(done8), 0);

        @(negedge clk);
        go(0, 1, 50, 50);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy8), 0);
        check("abort_done", 32'(done8), 0);
        check("abort_prod", 32'(p8), 0);
        rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort_stale", nd, 0);
        op(0, 1, 7, 9, 5, 32'd63, "s7x9");

        op(1, 1, -5, -8, 3, 32'd40, "w5_m5xm8");
        op(1, 1, 15, 7, 3, 32'd105, "w5_15x7");
        op(1, 1, -16, 7, 3, 32'h190, "w5_m16x7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
